// File: rtl/pipe_stage_reg_if.sv
// Bus between the hazard unit / upstream stage and a pipe_stage_reg instance.
// The master side drives control and the input slot. The slave side (the
// register chain) returns the last-stage payload and the stall counter.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SCNT_W = 16
) ();
  logic              Stall;
  logic              Flush;
  logic              in_Valid;
  logic [DATA_W-1:0] in_Data;
  logic [CTRL_W-1:0] in_Ctrl;
  logic              out_Valid;
  logic [DATA_W-1:0] out_Data;
  logic [CTRL_W-1:0] out_Ctrl;
  logic [SCNT_W-1:0] StallCount;

  modport master (
    output Stall, Flush, in_Valid, in_Data, in_Ctrl,
    input  out_Valid, out_Data, out_Ctrl, StallCount
  );

  modport slave (
    input  Stall, Flush, in_Valid, in_Data, in_Ctrl,
    output out_Valid, out_Data, out_Ctrl, StallCount
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: DEPTH back-to-back stages carrying
// valid, data and control payloads. The chain supports stall (hold), flush
// (bubble insertion) and a saturating count of stall cycles that hold real work.
// Every bubble carries data=0 and ctrl=NOP_CTRL. This makes out_Ctrl equal
// NOP_CTRL whenever out_Valid is low.
module pipe_stage_reg #(
  parameter int                 DATA_W   = 64,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
  parameter int                 DEPTH    = 1,
  parameter int                 SCNT_W   = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  pipe_stage_reg_if.slave bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              vld_q  [DEPTH];
  logic              vld_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [SCNT_W-1:0] cnt_q;
  logic [SCNT_W-1:0] cnt_d;
  logic              any_vld;

  // Next-state for the chain: flush beats stall, stall beats advance.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_vld   = any_vld | vld_q[i];
      vld_d[i]  = vld_q[i];
      data_d[i] = data_q[i];
      ctrl_d[i] = ctrl_q[i];
    end
    cnt_d = cnt_q;

    if (bus.Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_d[i]  = 1'b0;
        data_d[i] = '0;
        ctrl_d[i] = NOP_CTRL;
      end
    end else if (bus.Stall) begin
      if (any_vld) begin
        cnt_d = sat_inc(cnt_q);
      end
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
        ctrl_d[i] = ctrl_q[i-1];
      end
      vld_d[0]  = bus.in_Valid;
      data_d[0] = bus.in_Valid ? bus.in_Data : '0;
      ctrl_d[0] = bus.in_Valid ? bus.in_Ctrl : NOP_CTRL;
    end
  end

  // Stage registers and counter; reset overrides whatever flush/stall asked for.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
        ctrl_q[i] <= NOP_CTRL;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= vld_d[i];
        data_q[i] <= data_d[i];
        ctrl_q[i] <= ctrl_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  // ---- output boundary: last stage drives the bus directly (registered) ----
  assign bus.out_Valid  = vld_q[DEPTH-1];
  assign bus.out_Data   = data_q[DEPTH-1];
  assign bus.out_Ctrl   = ctrl_q[DEPTH-1];
  assign bus.StallCount = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Three instances with different DEPTH, NOP_CTRL
// and SCNT_W share one stimulus stream. A queue-based model of each pipeline
// predicts the outputs. Directed literal expectations pin the model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst   = 1'b1;
  logic        s_stall = 1'b0;
  logic        s_flush = 1'b0;
  logic        s_v     = 1'b0;
  logic [31:0] s_d     = '0;
  logic [7:0]  s_c     = '0;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .SCNT_W(16)) ifa ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .SCNT_W(16)) ifb ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .SCNT_W(4))  ifc ();

  assign ifa.Stall = s_stall; assign ifa.Flush = s_flush; assign ifa.in_Valid = s_v;
  assign ifa.in_Data = s_d;   assign ifa.in_Ctrl = s_c;
  assign ifb.Stall = s_stall; assign ifb.Flush = s_flush; assign ifb.in_Valid = s_v;
  assign ifb.in_Data = s_d;   assign ifb.in_Ctrl = s_c;
  assign ifc.Stall = s_stall; assign ifc.Flush = s_flush; assign ifc.in_Valid = s_v;
  assign ifc.in_Data = s_d;   assign ifc.in_Ctrl = s_c;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .NOP_CTRL(8'hA5), .DEPTH(2), .SCNT_W(16))
    u_a (.Clk(clk), .Reset(s_rst), .bus(ifa));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .NOP_CTRL(8'h00), .DEPTH(3), .SCNT_W(16))
    u_b (.Clk(clk), .Reset(s_rst), .bus(ifb));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .NOP_CTRL(8'h3C), .DEPTH(1), .SCNT_W(4))
    u_c (.Clk(clk), .Reset(s_rst), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each pipeline is a queue: front = newest item, back = what the output shows.
  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [7:0]  c;
  } item_t;

  item_t qa[$];
  item_t qb[$];
  item_t qc[$];
  int    ca = 0;
  int    cb = 0;
  int    cc = 0;
  bit    mdl_ok = 1'b0;

  function automatic void mstep(input int depth, input int cmax, input logic [7:0] nop,
                                inout item_t q[$], inout int cnt);
    item_t bub;
    item_t nw;
    bit    any;
    bub = '{v: 1'b0, d: 32'h0, c: nop};
    if (s_rst) begin
      q.delete();
      for (int i = 0; i < depth; i++) q.push_back(bub);
      cnt = 0;
    end else if (q.size() == 0) begin
      return;
    end else if (s_flush) begin
      for (int i = 0; i < depth; i++) q[i] = bub;
    end else if (s_stall) begin
      any = 1'b0;
      foreach (q[i]) if (q[i].v) any = 1'b1;
      if (any && cnt < cmax) cnt = cnt + 1;
    end else begin
      nw = s_v ? '{v: 1'b1, d: s_d, c: s_c} : bub;
      q.push_front(nw);
      void'(q.pop_back());
    end
  endfunction

  always @(posedge clk) begin
    mstep(2, 65535, 8'hA5, qa, ca);
    mstep(3, 65535, 8'h00, qb, cb);
    mstep(1, 15,    8'h3C, qc, cc);
    if (s_rst) mdl_ok = 1'b1;
  end

  task automatic cmp(input string n, input logic v, input logic [31:0] d, input logic [7:0] c,
                     input logic [63:0] cnt, input item_t e, input int ecnt);
    check({n, ".valid"}, 64'(v), 64'(e.v));
    check({n, ".data"},  64'(d), 64'(e.d));
    check({n, ".ctrl"},  64'(c), 64'(e.c));
    check({n, ".cnt"},   cnt,    64'(ecnt));
  endtask

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (mdl_ok) begin
      cmp("mdl.a", ifa.out_Valid, ifa.out_Data, ifa.out_Ctrl, 64'(ifa.StallCount), qa[qa.size()-1], ca);
      cmp("mdl.b", ifb.out_Valid, ifb.out_Data, ifb.out_Ctrl, 64'(ifb.StallCount), qb[qb.size()-1], cb);
      cmp("mdl.c", ifc.out_Valid, ifc.out_Data, ifc.out_Ctrl, 64'(ifc.StallCount), qc[qc.size()-1], cc);
    end
  end

  // Apply one cycle of stimulus and return at the following negedge.
  task automatic step(input bit r, input bit st, input bit fl, input bit v,
                      input logic [31:0] d, input logic [7:0] c);
    s_rst = r; s_stall = st; s_flush = fl; s_v = v; s_d = d; s_c = c;
    @(negedge clk);
  endtask

  initial begin
    // T1 reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("t1.a.valid", 64'(ifa.out_Valid), 64'h0);
    check("t1.a.data",  64'(ifa.out_Data),  64'h0);
    check("t1.a.ctrl",  64'(ifa.out_Ctrl),  64'hA5);
    check("t1.a.cnt",   64'(ifa.StallCount), 64'h0);

    // T2 latency on DEPTH=3
    step(0, 0, 0, 1, 32'd1, 8'h11);
    step(0, 0, 0, 1, 32'd2, 8'h12);
    step(0, 0, 0, 1, 32'd3, 8'h13);
    check("t2.b.valid1", 64'(ifb.out_Valid), 64'h1);
    check("t2.b.data1",  64'(ifb.out_Data),  64'd1);
    check("t2.b.ctrl1",  64'(ifb.out_Ctrl),  64'h11);
    step(0, 0, 0, 0, 0, 0);
    check("t2.b.data2",  64'(ifb.out_Data),  64'd2);
    step(0, 0, 0, 0, 0, 0);
    check("t2.b.data3",  64'(ifb.out_Data),  64'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // T3 stall holds on DEPTH=1
    step(0, 0, 0, 1, 32'd7, 8'h21);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 32'd9, 8'h22);
    check("t3.c.data_held", 64'(ifc.out_Data), 64'd7);
    check("t3.c.cnt",       64'(ifc.StallCount), 64'd4);
    check("t3.a.cnt",       64'(ifa.StallCount), 64'd4);
    step(0, 0, 0, 1, 32'd9, 8'h22);
    check("t3.c.data_rel",  64'(ifc.out_Data), 64'd9);

    // T4 flush beats stall
    step(0, 0, 0, 1, 32'd5, 8'h23);
    check("t4.c.data_pre", 64'(ifc.out_Data), 64'd5);
    step(0, 1, 1, 1, 32'h77, 8'h24);
    check("t4.c.valid", 64'(ifc.out_Valid), 64'h0);
    check("t4.c.ctrl",  64'(ifc.out_Ctrl),  64'h3C);
    check("t4.c.data",  64'(ifc.out_Data),  64'h0);
    check("t4.c.cnt",   64'(ifc.StallCount), 64'd4);

    // Reset during stall+flush behaves as plain reset
    step(0, 0, 0, 1, 32'd6, 8'h25);
    step(1, 1, 1, 1, 32'd8, 8'h26);
    check("rst.c.valid", 64'(ifc.out_Valid), 64'h0);
    check("rst.c.cnt",   64'(ifc.StallCount), 64'h0);
    check("rst.a.ctrl",  64'(ifa.out_Ctrl),  64'hA5);

    // Stall with empty chain does not count
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 32'd4, 8'h27);
    check("empty.c.cnt", 64'(ifc.StallCount), 64'h0);

    // T5 saturation on SCNT_W=4
    step(0, 0, 0, 1, 32'h11, 8'h31);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 32'h99, 8'h32);
    check("t5.c.cnt_sat", 64'(ifc.StallCount), 64'd15);
    check("t5.a.cnt",     64'(ifa.StallCount), 64'd20);
    check("t5.c.data",    64'(ifc.out_Data),   64'h11);
    step(0, 0, 1, 0, 0, 0);
    check("t5.c.cnt_flush", 64'(ifc.StallCount), 64'd15);

    // T6 invalid input squashes payload
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'hDEAD, 8'hFF);
    check("t6.b.valid", 64'(ifb.out_Valid), 64'h0);
    check("t6.b.ctrl",  64'(ifb.out_Ctrl),  64'h00);
    check("t6.b.data",  64'(ifb.out_Data),  64'h0);
    check("t6.a.ctrl",  64'(ifa.out_Ctrl),  64'hA5);
    check("t6.c.ctrl",  64'(ifc.out_Ctrl),  64'h3C);

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
           ($urandom % 3) != 0, $urandom, 8'($urandom));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
